// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: fetch step, canonical NOP and
// the {pc, inst} entry layout held by the instruction queue.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {pc, inst} entries. Flush wins over
// push/pop; a push into a full queue is accepted only alongside a pop.
module fetch_queue #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_s;
    logic             push_s;

    // Qualify pop/push so occupancy never under- or overflows.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (pop && (count_r != '0)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        if (push && ((count_r != CW'(DEPTH)) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Pointer and occupancy registers; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (push_s && !flush && !reset) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign empty     = (count_r == '0);
    assign full      = (count_r == CW'(DEPTH));
    assign count     = count_r;

endmodule

// File: rtl/fetch_unit_checker.sv
// Protocol checks for the fetch front end: no orphan responses, credit bound
// honoured, and the queue is never pushed while full without a pop.
module fetch_unit_checker #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          reset,
    input logic          imem_rsp_valid,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] queue_count,
    input logic          push,
    input logic          full,
    input logic          pop
);

    // Sample invariants on every active edge outside reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(imem_rsp_valid && (outstanding == '0)));
            assert (({1'b0, queue_count} + {1'b0, outstanding}) <= (CW + 1)'(DEPTH));
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, credit-limited in-order requests to
// instruction memory, response drop after redirect, and a decode-side queue.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter  int unsigned     XLEN     = 32,
    parameter  int unsigned     DEPTH    = 4,
    parameter  logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [CW-1:0]   queue_count
);

    localparam int unsigned     OW   = CW + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

    logic [XLEN-1:0]   fetch_pc_r;
    logic [XLEN-1:0]   fetch_pc_n;
    logic [XLEN-1:0]   rsp_pc_r;
    logic [XLEN-1:0]   rsp_pc_n;
    logic [CW-1:0]     outstanding_r;
    logic [CW-1:0]     outstanding_n;
    logic [CW-1:0]     drop_cnt_r;
    logic [CW-1:0]     drop_cnt_n;

    logic [CW-1:0]     q_count_s;
    logic              q_empty_s;
    logic              q_full_s;
    logic [2*XLEN-1:0] q_head_s;
    logic [XLEN-1:0]   redirect_base_s;
    logic [CW-1:0]     after_rsp_s;
    logic              req_valid_s;
    logic              issue_s;
    logic              rsp_keep_s;
    logic              pop_s;

    assign redirect_base_s = redirect_pc & ~XLEN'(3);
    assign after_rsp_s     = outstanding_r - CW'(imem_rsp_valid);

    // Handshake qualifiers: credit check, kept responses and decode pops.
    always_comb begin
        req_valid_s = !reset && !redirect_valid &&
                      (({1'b0, q_count_s} + {1'b0, outstanding_r}) < OW'(DEPTH));
        issue_s     = req_valid_s && imem_ready;
        rsp_keep_s  = imem_rsp_valid && !redirect_valid && (drop_cnt_r == '0);
        pop_s       = !q_empty_s && inst_ready && !redirect_valid;
    end

    // Next-state for PCs and credit/drop counters; redirect overrides all.
    always_comb begin
        fetch_pc_n    = fetch_pc_r;
        rsp_pc_n      = rsp_pc_r;
        outstanding_n = outstanding_r;
        drop_cnt_n    = drop_cnt_r;
        if (redirect_valid) begin
            fetch_pc_n    = redirect_base_s;
            rsp_pc_n      = redirect_base_s;
            outstanding_n = after_rsp_s;
            drop_cnt_n    = after_rsp_s;
        end else begin
            if (issue_s) begin
                fetch_pc_n = fetch_pc_r + STEP;
            end else begin
                fetch_pc_n = fetch_pc_r;
            end
            if (rsp_keep_s) begin
                rsp_pc_n = rsp_pc_r + STEP;
            end else begin
                rsp_pc_n = rsp_pc_r;
            end
            if (imem_rsp_valid && (drop_cnt_r != '0)) begin
                drop_cnt_n = drop_cnt_r - CW'(1);
            end else begin
                drop_cnt_n = drop_cnt_r;
            end
            outstanding_n = outstanding_r + CW'(issue_s) - CW'(imem_rsp_valid);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= '0;
            drop_cnt_r    <= '0;
        end else begin
            fetch_pc_r    <= fetch_pc_n;
            rsp_pc_r      <= rsp_pc_n;
            outstanding_r <= outstanding_n;
            drop_cnt_r    <= drop_cnt_n;
        end
    end

    fetch_queue #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_keep_s),
        .push_data ({rsp_pc_r, imem_rdata}),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head_data (q_head_s),
        .empty     (q_empty_s),
        .full      (q_full_s),
        .count     (q_count_s)
    );

    fetch_unit_checker #(
        .DEPTH (DEPTH)
    ) u_checker (
        .clk            (clk),
        .reset          (reset),
        .imem_rsp_valid (imem_rsp_valid),
        .outstanding    (outstanding_r),
        .queue_count    (q_count_s),
        .push           (rsp_keep_s),
        .full           (q_full_s),
        .pop            (pop_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_addr      = fetch_pc_r;
    assign inst_valid     = !q_empty_s;
    assign inst           = q_head_s[XLEN-1:0];
    assign inst_pc        = q_head_s[2*XLEN-1:XLEN];
    assign queue_count    = q_count_s;

endmodule
